// File: rtl/flag_select_reg.sv
// Registered N:1 flag-channel selector with sticky accumulation, change/sel_err pulses
// and a saturating load counter.
module flag_select_reg #(
    parameter int unsigned W     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   flags_in,
    input  logic             load,
    input  logic             sticky_en,
    input  logic             clr,
    output logic [W-1:0]     flag_out,
    output logic             flag_valid,
    output logic [W-1:0]     sticky_out,
    output logic             change,
    output logic             sel_err,
    output logic [CNT_W-1:0] load_cnt
);

    logic [W-1:0]     sel_flags;
    logic             in_range;
    logic             accept;
    logic             reject;

    logic [W-1:0]     flag_q, flag_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     sticky_q, sticky_d;
    logic             change_q, change_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Mux built as a bounded loop so an out-of-range sel never indexes past flags_in.
    always_comb begin
        sel_flags = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (int'(sel) == k) begin
                sel_flags = flags_in[k*W +: W];
            end
        end
    end

    assign in_range = int'(sel) < int'(N);
    assign accept   = load && in_range;
    assign reject   = load && !in_range;

    always_comb begin
        flag_d    = flag_q;
        valid_d   = valid_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        change_d  = 1'b0;
        sel_err_d = reject;

        // Clear first; an accepted load in the same cycle then builds on the cleared state.
        if (clr) begin
            valid_d  = 1'b0;
            sticky_d = '0;
            cnt_d    = '0;
        end

        if (accept) begin
            flag_d   = sel_flags;
            valid_d  = 1'b1;
            change_d = (sel_flags != flag_q);
            if (sticky_en) begin
                sticky_d = sticky_d | sel_flags;
            end
            if (cnt_d != {CNT_W{1'b1}}) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q    <= '0;
            valid_q   <= 1'b0;
            sticky_q  <= '0;
            change_q  <= 1'b0;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            flag_q    <= flag_d;
            valid_q   <= valid_d;
            sticky_q  <= sticky_d;
            change_q  <= change_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign flag_out   = flag_q;
    assign flag_valid = valid_q;
    assign sticky_out = sticky_q;
    assign change     = change_q;
    assign sel_err    = sel_err_q;
    assign load_cnt   = cnt_q;

endmodule
